// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared types, states and requantize/ReLU helpers for the MLP sequencer
// Optional feature macro: NN_SAT_EN (saturating requantize; wrap when undefined)
package nn_pkg;

  localparam int FX_W    = 16;
  localparam int FX_FRAC = 8;
  localparam int REQ_W   = 64;

  typedef logic signed [FX_W-1:0] fixed_t;

  typedef enum logic [1:0] {IDLE, L1, L2, DONE} state_e;

  localparam logic signed [REQ_W-1:0] FX_MAX = {{(REQ_W-FX_W+1){1'b0}}, {(FX_W-1){1'b1}}};
  localparam logic signed [REQ_W-1:0] FX_MIN = {{(REQ_W-FX_W+1){1'b1}}, {(FX_W-1){1'b0}}};

  // Arithmetic shift floors toward -inf; the fit to FX_W bits is clamp or wrap.
  function automatic fixed_t requant(input logic signed [REQ_W-1:0] v, input int frac);
    logic signed [REQ_W-1:0] s;
    s = v >>> frac;
`ifdef NN_SAT_EN
    if (s > FX_MAX) s = FX_MAX;
    else if (s < FX_MIN) s = FX_MIN;
`endif
    return s[FX_W-1:0];
  endfunction

  function automatic fixed_t relu(input fixed_t v);
    return v[FX_W-1] ? '0 : v;
  endfunction

endpackage

// File: rtl/nn_mac_unit.sv
// rtl/nn_mac_unit.sv - shared multiplier and accumulator with load/add control and requant output
module nn_mac_unit
  import nn_pkg::*;
#(
  parameter int WIDTH = FX_W,
  parameter int FRAC  = FX_FRAC,
  parameter int ACC_W = 35
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_i,
  input  logic                    first_i,
  input  logic signed [WIDTH-1:0] x_i,
  input  logic signed [WIDTH-1:0] w_i,
  output fixed_t                  res_o
);

  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]   sum;
  logic signed [ACC_W-1:0]   acc_q;

  always_comb begin
    prod = x_i * w_i;
    sum  = first_i ? ACC_W'(prod) : acc_q + ACC_W'(prod);
  end

  // res_o is the requantized value of the sum being committed this cycle.
  assign res_o = requant(REQ_W'(sum), FRAC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= sum;
    end
  end

endmodule

// File: rtl/nn_layer_sequencer.sv
// rtl/nn_layer_sequencer.sv - FSM-sequenced 2-layer fixed-point MLP over one shared MAC
// Optional feature macro: NN_SAT_EN (saturating requantize in both layers)
module nn_layer_sequencer
  import nn_pkg::*;
#(
  parameter int IN_SIZE  = 4,
  parameter int HIDDEN1  = 3,
  parameter int OUT_SIZE = 2,
  parameter int WIDTH    = FX_W,
  parameter int FRAC     = FX_FRAC,
  localparam int N1      = HIDDEN1 * IN_SIZE,
  localparam int N2      = OUT_SIZE * HIDDEN1,
  localparam int NT      = N1 + N2,
  localparam int AW      = $clog2(NT),
  localparam int MAXT    = (IN_SIZE > HIDDEN1) ? IN_SIZE : HIDDEN1,
  localparam int ACC_W   = 2 * WIDTH + $clog2(MAXT) + 1,
  localparam int MAXN    = (MAXT > OUT_SIZE) ? MAXT : OUT_SIZE,
  localparam int CW      = $clog2(MAXN + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [IN_SIZE*WIDTH-1:0]  in_data,
  output logic                      w_rd_en,
  output logic [AW-1:0]             w_addr,
  input  logic [WIDTH-1:0]          w_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_SIZE*WIDTH-1:0] out_data,
  output logic                      busy
);

  state_e state_q, state_d;

  logic signed [WIDTH-1:0]       x_q   [IN_SIZE];
  logic signed [WIDTH-1:0]       hid_q [HIDDEN1];
  logic [OUT_SIZE-1:0][WIDTH-1:0] out_q;

  // Address phase (request issue) and data phase (one cycle later, MAC active).
  logic          rd_en_q;
  logic [AW-1:0] addr_q;
  logic          a_layer_q, d_layer_q, d_vld_q;
  logic [CW-1:0] a_term_q, a_neu_q, d_term_q, d_neu_q;

  logic          accept, last_addr, a_last_term, a_last_neu, d_last_term, d_last;
  logic signed [WIDTH-1:0] mac_x;
  fixed_t        mac_res;

  assign accept      = in_valid && (state_q == IDLE);
  assign last_addr   = (addr_q == AW'(NT - 1));
  assign a_last_term = a_layer_q ? (a_term_q == CW'(HIDDEN1 - 1)) : (a_term_q == CW'(IN_SIZE - 1));
  assign a_last_neu  = a_layer_q ? (a_neu_q == CW'(OUT_SIZE - 1)) : (a_neu_q == CW'(HIDDEN1 - 1));
  assign d_last_term = d_layer_q ? (d_term_q == CW'(HIDDEN1 - 1)) : (d_term_q == CW'(IN_SIZE - 1));
  assign d_last      = d_vld_q && d_layer_q && d_last_term && (d_neu_q == CW'(OUT_SIZE - 1));

  always_comb begin
    mac_x = '0;
    if (d_layer_q) begin
      for (int h = 0; h < HIDDEN1; h++) if (d_term_q == CW'(h)) mac_x = hid_q[h];
    end else begin
      for (int i = 0; i < IN_SIZE; i++) if (d_term_q == CW'(i)) mac_x = x_q[i];
    end
  end

  nn_mac_unit #(.WIDTH(WIDTH), .FRAC(FRAC), .ACC_W(ACC_W)) u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (d_vld_q),
    .first_i (d_term_q == '0),
    .x_i     (mac_x),
    .w_i     (w_data),
    .res_o   (mac_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = L1;
      end
      L1:   if (rd_en_q && addr_q == AW'(N1 - 1)) state_d = L2;
      L2:   if (d_last) state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en_q   <= 1'b0;
      addr_q    <= '0;
      a_layer_q <= 1'b0;
      a_term_q  <= '0;
      a_neu_q   <= '0;
      d_vld_q   <= 1'b0;
      d_layer_q <= 1'b0;
      d_term_q  <= '0;
      d_neu_q   <= '0;
      out_q     <= '0;
      for (int i = 0; i < IN_SIZE; i++) x_q[i] <= '0;
      for (int h = 0; h < HIDDEN1; h++) hid_q[h] <= '0;
    end else begin
      d_vld_q   <= rd_en_q;
      d_layer_q <= a_layer_q;
      d_term_q  <= a_term_q;
      d_neu_q   <= a_neu_q;
      if (accept) begin
        for (int i = 0; i < IN_SIZE; i++) x_q[i] <= in_data[i*WIDTH +: WIDTH];
        rd_en_q   <= 1'b1;
        addr_q    <= '0;
        a_layer_q <= 1'b0;
        a_term_q  <= '0;
        a_neu_q   <= '0;
      end else if (rd_en_q) begin
        addr_q  <= last_addr ? '0 : addr_q + 1'b1;
        rd_en_q <= !last_addr;
        if (a_last_term) begin
          a_term_q <= '0;
          if (a_last_neu) begin
            a_neu_q   <= '0;
            a_layer_q <= 1'b1;
          end else begin
            a_neu_q <= a_neu_q + 1'b1;
          end
        end else begin
          a_term_q <= a_term_q + 1'b1;
        end
      end
      if (d_vld_q && d_last_term) begin
        if (!d_layer_q) begin
          for (int h = 0; h < HIDDEN1; h++) if (d_neu_q == CW'(h)) hid_q[h] <= relu(mac_res);
        end else begin
          for (int o = 0; o < OUT_SIZE; o++) if (d_neu_q == CW'(o)) out_q[o] <= mac_res;
        end
      end
    end
  end

  assign w_rd_en  = rd_en_q;
  assign w_addr   = addr_q;
  assign out_data = out_q;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// tb/tb_nn_layer_sequencer.sv - scoreboard bench for nn_layer_sequencer (honours NN_SAT_EN)
module tb_nn_layer_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic        w_rd_en;
  logic [4:0]  w_addr;
  logic [15:0] w_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cyc = 1000;
  logic ov_prev = 1'b0;
  logic [15:0] mem [18];
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  nn_layer_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .w_rd_en   (w_rd_en),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  // Weight memory: one-cycle read latency, junk on the bus when idle.
  always @(posedge clk) w_data <= w_rd_en ? mem[w_addr] : 16'($urandom);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 1000;
    else if (in_valid && in_ready) cyc <= 1;
    else if (cyc < 1000) cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (w_rd_en) check("rd_window_addr", {27'd0, w_addr}, (cyc >= 1 && cyc <= 18) ? 32'(cyc - 1) : 32'hDEAD);
      if (cyc == 19) check("rd_stop", {31'd0, w_rd_en}, 32'd0);
      if (out_valid && !ov_prev) check("latency", 32'(cyc), 32'd20);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", out_data, 32'hFFFF_FFFF);
        else check("out_data", out_data, exp_q.pop_front());
      end
      ov_prev <= out_valid;
    end else begin
      ov_prev <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_diag();
    for (int a = 0; a < 18; a++) mem[a] = '0;
    mem[0] = 16'd256; mem[5] = 16'd256; mem[10] = 16'd256;
    mem[12] = 16'd256; mem[16] = 16'd256;
  endtask

  task automatic send(input logic [15:0] x0, x1, x2, x3, input logic [31:0] exp, input bit push);
    int n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_data  = {x3, x2, x1, x0};
    in_valid = 1'b1;
    if (push) exp_q.push_back(exp);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin tick(); n++; end
    check("drain", 32'(exp_q.size()), 32'd0);
    tick();
  endtask

  initial begin
    logic [15:0] exp3;
    int n;
`ifdef NN_SAT_EN
    exp3 = 16'h7FFF;
`else
    exp3 = 16'h4000;
`endif
    load_diag();
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rd", {26'd0, w_rd_en, w_addr}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    send(16'd256, 16'd512, 16'd768, 16'd1024, {16'd512, 16'd256}, 1'b1);
    drain();
    send(-16'sd256, 16'd512, 16'd768, 16'd1024, {16'd512, 16'd0}, 1'b1);
    drain();

    for (int a = 0; a < 18; a++) mem[a] = '0;
    for (int a = 0; a < 4; a++) mem[a] = 16'd25600;
    mem[12] = 16'd256;
    send(16'd1024, 16'd1024, 16'd1024, 16'd1024, {16'd0, exp3}, 1'b1);
    drain();

    load_diag();
    out_ready = 1'b0;
    send(16'd256, 16'd512, 16'd768, 16'd1024, {16'd512, 16'd256}, 1'b1);
    n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    check("stall_valid", {31'd0, out_valid}, 32'd1);
    for (int k = 0; k < 10; k++) begin
      check("stall_data", out_data, {16'd512, 16'd256});
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      in_valid = 1'b1;
      in_data  = {4{16'h1234}};
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();
    send(-16'sd256, 16'd512, 16'd768, 16'd1024, {16'd512, 16'd0}, 1'b1);
    drain();

    send(16'd1024, 16'd1024, 16'd1024, 16'd1024, 32'd0, 1'b0);
    repeat (4) tick();
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_rd", {26'd0, w_rd_en, w_addr}, 32'd0);
    check("midrst_out", {30'd0, out_valid, busy}, 32'd0);
    check("midrst_data", out_data, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    send(16'd256, 16'd512, 16'd768, 16'd1024, {16'd512, 16'd256}, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
